spi_master: RTL and testbench

Mode-0 (CPOL=0, CPHA=0), MSb-first SPI master for the SPI subsystem. It drives SCLK, SS and MOSI to one SPI slave on the same board, and samples MISO. It generates SCLK from clk_i by integer division. The host side uses a byte-level valid/ready interface, and back-to-back bytes are sent as one burst with SS held low.

---
 rtl/spi_master.sv | 96 +++++++++
 tb/tb_spi_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: mode-0 MSb-first SPI master with byte valid/ready host side and burst SS
module spi_master #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned SS_LEAD = 8,
  parameter int unsigned SS_TRAIL = 8,
  parameter int unsigned SS_IDLE = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       ss_o,
  output logic       sdo_o,
  input  logic       sdi_i
);
  typedef enum logic [2:0] {IDLE, LEAD, XFER, NEXT, TRAIL, GAP} state_t;
  state_t state, state_n;
  logic [15:0] timer, lim;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic last, accept, tmr_done, half_end;
  assign tx_ready_o = (state == IDLE) || (state == NEXT);
  assign busy_o = state != IDLE;
  assign accept = tx_valid_i && tx_ready_o;
  assign lim = (state == LEAD) ? 16'(SS_LEAD - 1) :
               (state == XFER) ? 16'(HALF_PERIOD - 1) :
               (state == TRAIL) ? 16'(SS_TRAIL - 1) : 16'(SS_IDLE - 1);
  assign tmr_done = timer == lim;
  assign half_end = (state == XFER) && tmr_done;
  // next-state selection
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = accept ? LEAD : IDLE;
      LEAD:  state_n = tmr_done ? XFER : LEAD;
      XFER:  state_n = (half_end && sclk_o && bit_cnt == 3'd7) ? (last ? TRAIL : NEXT) : XFER;
      NEXT:  state_n = accept ? XFER : NEXT;
      TRAIL: state_n = tmr_done ? GAP : TRAIL;
      GAP:   state_n = tmr_done ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // state register; the timer restarts on every state change and every SCLK half period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= (state_n != state || tmr_done || state == IDLE || state == NEXT) ? '0 : timer + 16'd1;
    end
  end
  // SPI pins, shift registers and received-byte strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_o <= 1'b0;
      ss_o <= 1'b1;
      sdo_o <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o <= '0;
      bit_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      last <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (accept) begin
        tx_sr <= tx_data_i[6:0];
        last <= tx_last_i;
        sdo_o <= tx_data_i[7];
        ss_o <= 1'b0;
      end
      if (half_end) begin
        sclk_o <= ~sclk_o;
        if (!sclk_o) rx_sr <= {rx_sr[6:0], sdi_i};
        else if (bit_cnt == 3'd7) begin
          rx_data_o <= rx_sr;
          rx_valid_o <= 1'b1;
          bit_cnt <= 3'd0;
        end else begin
          sdo_o <= tx_sr[6];
          tx_sr <= {tx_sr[5:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (state == TRAIL && tmr_done) ss_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed stimulus with queue scoreboard and bus monitor for spi_master
module tb_spi_master;
  localparam int HP = 4;
  localparam int SL = 8;
  localparam int ST = 8;
  localparam int SI = 8;
  logic clk_i = 1'b0;
  logic rst_i, tx_valid_i, tx_last_i, loop;
  logic [7:0] tx_data_i;
  logic sdi_i;
  logic tx_ready_o, rx_valid_o, busy_o, sclk_o, ss_o, sdo_o;
  logic [7:0] rx_data_o;
  int cmp = 0;
  int mis = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] mosi_exp[$];
  logic [7:0] slv_q[$];
  int burst_q[$];
  int low_q[$];
  logic [7:0] s_sr = 8'h00;
  logic [7:0] m_sr = 8'h00;
  logic s_loaded, prev_ss, prev_sclk, prev_last, prev_rxv, hp_arm, hi_ok;
  int s_cnt, m_cnt, hp_cnt, lowcnt, hicnt, pulses;

  spi_master #(.HALF_PERIOD(HP), .SS_LEAD(SL), .SS_TRAIL(ST), .SS_IDLE(SI)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_data_i(tx_data_i), .tx_last_i(tx_last_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .busy_o(busy_o), .sclk_o(sclk_o), .ss_o(ss_o), .sdo_o(sdo_o), .sdi_i(sdi_i)
  );

  always #5 clk_i = ~clk_i;
  assign sdi_i = loop ? sdo_o : s_sr[7];

  task automatic chk(input string n, input int got, input int exp);
    cmp++;
    if (got != exp) begin
      mis++;
      $display("FAIL %s: got %0h, required %0h", n, got, exp);
    end
  endtask

  task automatic chk_rng(input string n, input int got, input int lo, input int hi);
    cmp++;
    if (got < lo || got > hi) begin
      mis++;
      $display("FAIL %s: got %0d, required %0d..%0d", n, got, lo, hi);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [7:0] s);
    mosi_exp.push_back(d);
    rx_exp.push_back(s);
    slv_q.push_back(s);
  endtask

  task automatic expect_burst(input int p, input int l);
    burst_q.push_back(p);
    low_q.push_back(l);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    logic ok;
    n = 0;
    tx_valid_i = 1'b1;
    tx_data_i = d;
    tx_last_i = l;
    do begin
      @(negedge clk_i);
      ok = tx_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!ok && n < 5000);
    if (!ok) begin
      cmp++;
      mis++;
      $display("FAIL send_timeout: got no accept, required accept of %0h", d);
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy_o && n < 5000);
    if (busy_o) begin
      cmp++;
      mis++;
      $display("FAIL idle_timeout: got busy 1, required 0");
    end
    @(posedge clk_i);
    #1;
  endtask

  // monitor: scoreboard pops, SPI bus timing and bench slave
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_ss = 1'b1;
      prev_sclk = 1'b0;
      prev_last = 1'b1;
      prev_rxv = 1'b0;
      hp_arm = 1'b0;
      hi_ok = 1'b0;
      s_loaded = 1'b0;
      hp_cnt = 0;
      lowcnt = 0;
      hicnt = 0;
      pulses = 0;
      m_cnt = 0;
      s_cnt = 0;
    end else begin
      if (rx_valid_o) begin
        chk("rx_pulse_width", int'(prev_rxv), 0);
        if (rx_exp.size() == 0) begin
          cmp++;
          mis++;
          $display("FAIL rx_unexpected: got %0h, required no pulse", rx_data_o);
        end else chk("rx_data", int'(rx_data_o), int'(rx_exp.pop_front()));
      end
      if (hp_arm) begin
        if (sclk_o) begin
          chk("next_byte_low", hp_cnt, HP);
          hp_arm = 1'b0;
        end else hp_cnt++;
      end
      if (tx_valid_i && tx_ready_o) begin
        if (prev_last) chk("accept_in_idle", int'(busy_o), 0);
        else begin
          hp_arm = 1'b1;
          hp_cnt = 0;
        end
        prev_last = tx_last_i;
      end
      if (prev_ss && !ss_o) begin
        if (hi_ok) chk_rng("ss_idle_len", hicnt, SI, 100000);
        lowcnt = 0;
        pulses = 0;
        m_cnt = 0;
        s_cnt = 0;
        if (!s_loaded) s_sr = slv_q.size() != 0 ? slv_q.pop_front() : 8'h00;
        s_loaded = 1'b0;
      end
      if (!prev_ss && ss_o) begin
        if (burst_q.size() == 0) begin
          cmp++;
          mis++;
          $display("FAIL burst_unexpected: got %0d pulses, required no burst", pulses);
        end else begin
          int e;
          chk("sclk_pulses", pulses, burst_q.pop_front());
          e = low_q.pop_front();
          if (e >= 0) chk_rng("ss_low_len", lowcnt, e - 1, e + 1);
        end
        hicnt = 0;
        hi_ok = 1'b1;
      end
      if (!prev_sclk && sclk_o) begin
        pulses++;
        chk("ss_low_at_sclk", int'(ss_o), 0);
        m_sr = {m_sr[6:0], sdo_o};
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          if (mosi_exp.size() == 0) begin
            cmp++;
            mis++;
            $display("FAIL mosi_unexpected: got %0h, required no byte", m_sr);
          end else chk("mosi", int'(m_sr), int'(mosi_exp.pop_front()));
        end
      end
      if (prev_sclk && !sclk_o) begin
        s_cnt++;
        if (s_cnt == 8) begin
          s_cnt = 0;
          s_loaded = slv_q.size() != 0;
          s_sr = s_loaded ? slv_q.pop_front() : 8'h00;
        end else s_sr = s_sr << 1;
      end
      if (!ss_o) lowcnt++;
      else hicnt++;
      prev_ss = ss_o;
      prev_sclk = sclk_o;
      prev_rxv = rx_valid_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis + 1);
    $fatal(1);
  end

  initial begin
    int ok, r, n;
    logic p;
    logic [7:0] burst[4];
    rst_i = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i = 8'h00;
    tx_last_i = 1'b0;
    loop = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ss", int'(ss_o), 1);
    chk("rst_sclk", int'(sclk_o), 0);
    chk("rst_sdo", int'(sdo_o), 0);
    chk("rst_rx_valid", int'(rx_valid_o), 0);
    chk("rst_rx_data", int'(rx_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    // single byte
    expect_byte(8'hA5, 8'h3C);
    expect_burst(8, SL + 16 * HP + ST);
    send(8'hA5, 1'b1);
    wait_idle();
    // three-byte burst
    expect_byte(8'h01, 8'h5A);
    expect_byte(8'h80, 8'hC3);
    expect_byte(8'hFF, 8'h00);
    expect_burst(24, -1);
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    wait_idle();
    // host stalls 50 cycles between bytes of a burst
    expect_byte(8'h69, 8'h0F);
    expect_byte(8'h96, 8'hF0);
    expect_burst(16, -1);
    send(8'h69, 1'b0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(busy_o && tx_ready_o) && n < 5000);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy_o && tx_ready_o && !ss_o && !sclk_o) ok++;
      @(negedge clk_i);
    end
    chk("next_hold", ok, 50);
    @(posedge clk_i);
    #1;
    send(8'h96, 1'b1);
    wait_idle();
    // valid held high across two single-byte bursts
    expect_byte(8'h11, 8'hAA);
    expect_byte(8'h22, 8'h55);
    expect_burst(8, SL + 16 * HP + ST);
    expect_burst(8, SL + 16 * HP + ST);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wait_idle();
    // reset after the third rising SCLK edge
    slv_q.push_back(8'h77);
    send(8'hC6, 1'b1);
    r = 0;
    p = sclk_o;
    n = 0;
    while (r < 3 && n < 5000) begin
      @(negedge clk_i);
      if (sclk_o && !p) r++;
      p = sclk_o;
      n++;
    end
    chk("rst_wait_edges", r, 3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_ss", int'(ss_o), 1);
    chk("midrst_sclk", int'(sclk_o), 0);
    chk("midrst_sdo", int'(sdo_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_rx_valid", int'(rx_valid_o), 0);
    chk("midrst_rx_data", int'(rx_data_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    expect_byte(8'h3E, 8'hE3);
    expect_burst(8, SL + 16 * HP + ST);
    send(8'h3E, 1'b1);
    wait_idle();
    // loopback four-byte burst
    loop = 1'b1;
    burst = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) begin
      mosi_exp.push_back(burst[i]);
      rx_exp.push_back(burst[i]);
    end
    expect_burst(32, -1);
    for (int i = 0; i < 4; i++) send(burst[i], i == 3);
    wait_idle();
    repeat (4) @(negedge clk_i);
    chk("rx_q_drained", rx_exp.size(), 0);
    chk("mosi_q_drained", mosi_exp.size(), 0);
    chk("burst_q_drained", burst_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
